// File: rtl/led_pattern_engine.sv
// Multi-mode LED pattern generator: bounce, wrap, fill/drain and blink over an N-wide LED bank.
// Define LED_PATTERN_BLINK_EN to build mode 3 as blink; otherwise mode 3 aliases bounce.
module led_pattern_engine #(
    parameter int unsigned N_LEDS   = 7,
    parameter int unsigned TICK_DIV = 25000000
) (
    input  logic              clk_50M,
    input  logic              rst,
    input  logic              enable,
    input  logic [1:0]        mode,
    input  logic [1:0]        speed,
    output logic [N_LEDS-1:0] leds,
    output logic              step
);
    localparam int unsigned PreW = $clog2(TICK_DIV);
    localparam int unsigned PosW = $clog2(N_LEDS + 1);
    localparam logic [N_LEDS:0] LsbOne = {{N_LEDS{1'b0}}, 1'b1};

    typedef enum logic [1:0] {ModeBounce, ModeWrap, ModeFill, ModeBlink} mode_e;

    logic [PreW-1:0]   pre_q, pre_d;
    logic [2:0]        sdiv_q, sdiv_d, sdiv_inc, spd_mask;
    logic [PosW-1:0]   pos_q, pos_d, top;
    logic              dir_q, dir_d;
    logic [1:0]        mode_q;
    mode_e             eff_mode;
    logic              tick, adv, restart;
    logic [N_LEDS:0]   onehot, fill_mask;
    logic [N_LEDS-1:0] leds_d;
    logic              step_d;
`ifdef LED_PATTERN_BLINK_EN
    logic              ph_q, ph_d;
`endif

    always_comb begin
        tick     = (pre_q == PreW'(TICK_DIV - 1));
        sdiv_inc = sdiv_q + 3'd1;
        case (speed)
            2'd0:    spd_mask = 3'b000;
            2'd1:    spd_mask = 3'b001;
            2'd2:    spd_mask = 3'b011;
            default: spd_mask = 3'b111;
        endcase
        // Post-increment count, so the first advance after a restart lands 2^speed ticks in.
        adv     = tick && ((sdiv_inc & spd_mask) == 3'd0);
        restart = (mode != mode_q);

        eff_mode = mode_e'(mode);
`ifndef LED_PATTERN_BLINK_EN
        if (eff_mode == ModeBlink) eff_mode = ModeBounce;
`endif
        top = (eff_mode == ModeFill) ? PosW'(N_LEDS) : PosW'(N_LEDS - 1);

        pre_d  = tick ? '0 : pre_q + PreW'(1);
        sdiv_d = tick ? sdiv_inc : sdiv_q;
        pos_d  = pos_q;
        dir_d  = dir_q;
        step_d = 1'b0;
`ifdef LED_PATTERN_BLINK_EN
        ph_d   = ph_q;
`endif

        if (!enable || restart) begin
            pre_d  = '0;
            sdiv_d = '0;
            pos_d  = '0;
            dir_d  = 1'b0;
`ifdef LED_PATTERN_BLINK_EN
            ph_d   = 1'b0;
`endif
        end else if (adv) begin
            step_d = 1'b1;
            case (eff_mode)
                ModeWrap: pos_d = (pos_q == top) ? '0 : pos_q + PosW'(1);
`ifdef LED_PATTERN_BLINK_EN
                ModeBlink: ph_d = ~ph_q;
`endif
                default: begin
                    // Bounce and fill share the endpoint-once sweep, differing only in top.
                    if (!dir_q) begin
                        if (pos_q == top) begin
                            pos_d = top - PosW'(1);
                            dir_d = 1'b1;
                        end else begin
                            pos_d = pos_q + PosW'(1);
                        end
                    end else begin
                        if (pos_q == '0) begin
                            pos_d = PosW'(1);
                            dir_d = 1'b0;
                        end else begin
                            pos_d = pos_q - PosW'(1);
                        end
                    end
                end
            endcase
        end

        onehot    = LsbOne << pos_d;
        fill_mask = onehot - LsbOne;
        leds_d    = '0;
        if (enable) begin
            case (eff_mode)
                ModeFill: leds_d = fill_mask[N_LEDS-1:0];
`ifdef LED_PATTERN_BLINK_EN
                ModeBlink: leds_d = {N_LEDS{ph_d}};
`endif
                default: leds_d = onehot[N_LEDS-1:0];
            endcase
        end
    end

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            pre_q  <= '0;
            sdiv_q <= '0;
            pos_q  <= '0;
            dir_q  <= 1'b0;
            mode_q <= 2'd0;
            leds   <= '0;
            step   <= 1'b0;
`ifdef LED_PATTERN_BLINK_EN
            ph_q   <= 1'b0;
`endif
        end else begin
            pre_q  <= pre_d;
            sdiv_q <= sdiv_d;
            pos_q  <= pos_d;
            dir_q  <= dir_d;
            mode_q <= mode;
            leds   <= leds_d;
            step   <= step_d;
`ifdef LED_PATTERN_BLINK_EN
            ph_q   <= ph_d;
`endif
        end
    end
endmodule

// File: doc/led_pattern_engine.md
# led_pattern_engine

Parametrised multi-mode LED pattern generator; successor to the single-mode running-light block. Divides the board clock to a step rate, advances one of four patterns over an N-wide LED bank, and drives the LED pins directly. Adds a runtime speed select, a step strobe for other display logic, and clean restart on mode change or disable.

## Interface
Parameters:
- N_LEDS, 7, LED count; legal range 2..32.
- TICK_DIV, 25000000, clocks per base tick; legal range ≥2 (bench uses 4).

Ports:
- clk_50M  in  1  system clock, all logic on rising edge.
- rst  in  1  reset; one clock, asynchronous, active-high.
- enable  in  1  run control. 0 means LEDs dark and pattern state cleared.
- mode  in  2  0 bounce, 1 wrap, 2 fill/drain, 3 blink.
- speed  in  2  steps occur every 2^speed base ticks.
- leds  out  N_LEDS  registered LED drive, bit 0 is the first LED.
- step  out  1  one-clock strobe, high in the cycle the leds output shows a new frame.

## Operation
- Prescaler `pre` counts 0..TICK_DIV-1 and wraps. `tick` = (pre==TICK_DIV-1).
- Divider `sdiv` is 3 bits and increments on tick. `adv` = tick & (sdiv[speed-1:0]==0), with speed 0 giving adv=tick.
- Pattern state:
  - `pos` is $clog2(N_LEDS+1) bits.
  - `dir` is 0 for forward, 1 for backward.
  - `ph` is the blink phase.
  - Frame 0 is pos=0, dir=0, ph=0.
- On adv:
  - **Bounce:** if dir=0, when pos==N_LEDS-1 set pos=N_LEDS-2 and dir=1, otherwise pos+1. If dir=1, when pos==0 set pos=1 and dir=0, otherwise pos-1. Endpoints are shown once per sweep.
  - **Wrap:** pos = (pos==N_LEDS-1) ? 0 : pos+1.
  - **Fill:** pos runs 0..N_LEDS, then back to 0, using the same endpoint-once rule as bounce.
  - **Blink:** ph toggles.
- Frame decode:
  - Bounce and wrap: leds = 1<<pos.
  - Fill: leds = (1<<pos)-1, so pos=N_LEDS lights all LEDs.
  - Blink: leds = all ones if ph=1, else all zeros.
- Decode is registered. Whenever enable=1, leds updates every clock.
- Mode change: mode is registered into `mode_q` each clock. When mode != mode_q, in that clock:
  - pattern state returns to frame 0;
  - pre and sdiv are cleared;
  - no adv takes effect.
- enable=0:
  - pre, sdiv and pattern state are held at 0.
  - leds=0 and step=0 from the next clock.
- Simultaneous events: a mode change or enable=0 in the same clock as tick takes priority, and the step is dropped.
- A speed change mid-run needs no restart. The new divisor applies from the next tick.

## Timing
- Reset values: leds=0, step=0, pre=0, sdiv=0, pos=0, dir=0, ph=0, mode_q=0.
- Reset may assert mid-sweep; all state returns to reset values immediately.
- enable rising edge: leds shows frame 0 one clock later (bounce and wrap 0…01, fill and blink 0), with no step strobe.
- First advance comes TICK_DIV×2^speed clocks after enable rises or a mode restart.
- Latency from adv to new leds is one clock. step is high in that same cycle.
- Steady step period is TICK_DIV×2^speed clocks.
- Periods for N_LEDS=7:
  - bounce: 12 steps
  - wrap: 7 steps
  - fill: 14 steps
  - blink: 2 steps
- No combinational path from any input to an output.

## Configuration
- LED_PATTERN_BLINK_EN defined: mode 3 is blink as specified above.
- Not defined:
  - ph register and blink decode are removed.
  - mode 3 behaves exactly as mode 0 (bounce).
  - A 0↔3 mode change still triggers the restart.

## Test plan
- **Reset and enable:** TICK_DIV=4, N_LEDS=7, mode=0, speed=0; release rst, enable=1.
  - leds=0000001 one clock after enable.
  - step pulses every 4 clocks.
  - leds sequence 02,04,08,10,20,40,20,10,08,04,02,01,02 (hex).
- **Wrap and fill:** mode=1 gives 01..40 then 01. mode=2 gives 00,01,03,…,7F,3F,…,00, with 7F exactly once.
- **Speed:** speed=2 gives step spacing of 16 clocks. Change to speed=0 mid-run: spacing becomes 4 within one tick, and the pattern is not restarted.
- **Restarts:**
  - Mode change from 0 to 1 at pos=4 coinciding with tick: no step, leds=01, next step 16 clocks later at speed=2.
  - enable=0 mid-sweep: leds=0 next clock, no further step.
- **Blink and config:** mode=3 with LED_PATTERN_BLINK_EN gives leds 00→7F→00 each step. Without the macro, mode=3 sequence equals mode 0.
- **Async reset:** rst asserted mid-cycle at pos=5: leds=0 and step=0 immediately without a clock edge. After release with enable=1, leds=01.
